// File: rtl/jetson_spi_slave_pkg.sv
// Shared types and constants for the Jetson SPI responder: frame layout,
// FSM state encoding and a helper that packs {idx, data} into a frame word.
package jetson_spi_slave_pkg;

   localparam int SPI_FRAME_BITS = 32;
   localparam int SPI_IDX_BITS   = 4;
   localparam int SPI_DATA_BITS  = 28;
   localparam logic [SPI_IDX_BITS-1:0] SPI_IDX_STATUS = 4'h0;

   // Bit counter must be able to hold the value SPI_FRAME_BITS itself
   localparam int BITCNT_W = $clog2(SPI_FRAME_BITS) + 1;

   typedef logic [SPI_FRAME_BITS-1:0] spi_word_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_t;

   function automatic spi_word_t make_word(input logic [SPI_IDX_BITS-1:0] idx,
                                           input logic [SPI_DATA_BITS-1:0] data);
      return {idx, data};
   endfunction

endpackage

// File: rtl/jetson_spi_slave_if.sv
// Bundle of the SPI pins, received-frame strobe, outbound message handshake,
// live status word and error counter. The slave modport is the FPGA side,
// the master modport is whatever drives the pins and consumes the frames.
interface jetson_spi_slave_if;
   import jetson_spi_slave_pkg::*;

   logic                      spi_clk;
   logic                      spi_cs;
   logic                      spi_mosi;
   logic                      spi_miso;
   logic                      rx_valid;
   logic [SPI_IDX_BITS-1:0]   rx_index;
   logic [SPI_DATA_BITS-1:0]  rx_data;
   logic                      tx_valid;
   logic                      tx_ready;
   logic [SPI_IDX_BITS-1:0]   tx_index;
   logic [SPI_DATA_BITS-1:0]  tx_data;
   logic [SPI_DATA_BITS-1:0]  status_in;
   logic [7:0]                frame_err;

   modport slave (
      input  spi_clk, spi_cs, spi_mosi,
      output spi_miso,
      output rx_valid, rx_index, rx_data,
      input  tx_valid, tx_index, tx_data,
      output tx_ready,
      input  status_in,
      output frame_err
   );

   modport master (
      output spi_clk, spi_cs, spi_mosi,
      input  spi_miso,
      input  rx_valid, rx_index, rx_data,
      output tx_valid, tx_index, tx_data,
      input  tx_ready,
      output status_in,
      input  frame_err
   );

endinterface

// File: rtl/jetson_spi_slave_tx_fifo.sv
// Synchronous FIFO for outbound reply words. The head can be peeked without
// being consumed so a reply is only retired once its frame completes cleanly.
// A push is accepted while full if a pop happens in the same cycle.
module spi_tx_fifo
   import jetson_spi_slave_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  spi_word_t push_word,
   input  logic      pop,
   output spi_word_t peek_word,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   spi_word_t      mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign peek_word = mem[rd_ptr[AW-1:0]];

   // Pointer bookkeeping; the extra MSB distinguishes full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array needs no reset; emptiness is tracked by the pointers
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
   end

endmodule

// File: rtl/jetson_spi_slave.sv
// FPGA-side SPI mode-0 responder for the Jetson link. Receives 32-bit
// {idx, data} frames and answers in the same frame with the oldest queued
// outbound message, or {idx 0, status_in} when nothing is queued.
// Optional feature macro: YABOT_SPI_ERRCNT_EN enables the saturating
// aborted-frame counter on frame_err; without it frame_err reads 8'h00.
module jetson_spi_slave
   import jetson_spi_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TXQ_DEPTH   = 16
) (
   input logic clk,
   input logic rst,
   jetson_spi_slave_if.slave bus
);

   localparam logic [BITCNT_W-1:0] FRAME_CNT = BITCNT_W'(SPI_FRAME_BITS);

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_prev;
   logic                   cs_prev;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   cs_rise;
   logic                   cs_fall;

   spi_state_t             state;
   spi_state_t             next_state;

   logic                   load_reply;
   logic                   frame_done;
   logic                   frame_ok;
   logic                   shift_in;
   logic                   shift_out;
   logic                   miso_d;

   spi_word_t              reply_reg;
   spi_word_t              rx_shift;
   logic                   reply_from_fifo;
   logic [BITCNT_W-1:0]    bitcnt;
   logic                   overrun;

   logic                   rx_valid_q;
   logic [SPI_IDX_BITS-1:0]  rx_index_q;
   logic [SPI_DATA_BITS-1:0] rx_data_q;

   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   spi_word_t              fifo_head;

   // Bring the asynchronous SPI pins into the clk domain; cs idles high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // One extra flop on clock and select so their edges can be detected
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_rise   = cs_s & ~cs_prev;
   assign cs_fall   = ~cs_s & cs_prev;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // FSM next state: a frame spans exactly one chip-select low period
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (cs_fall) next_state = ST_SHIFT;
         ST_SHIFT: if (cs_rise) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: datapath controls and the MISO pin, held low outside a frame
   always_comb begin
      load_reply = (state == ST_IDLE) && cs_fall;
      frame_done = (state == ST_SHIFT) && cs_rise;
      frame_ok   = frame_done && (bitcnt == FRAME_CNT) && !overrun;
      shift_in   = (state == ST_SHIFT) && sclk_rise;
      shift_out  = (state == ST_SHIFT) && sclk_fall;
      fifo_pop   = frame_ok && reply_from_fifo;
      miso_d     = (state == ST_SHIFT) ? reply_reg[SPI_FRAME_BITS-1] : 1'b0;
   end

   assign bus.spi_miso = miso_d;

   // Reply is latched at frame start so later pushes or status changes cannot disturb it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reply_reg       <= '0;
         reply_from_fifo <= 1'b0;
      end else if (load_reply) begin
         reply_reg       <= fifo_empty ? make_word(SPI_IDX_STATUS, bus.status_in) : fifo_head;
         reply_from_fifo <= !fifo_empty;
      end else if (shift_out) begin
         reply_reg       <= {reply_reg[SPI_FRAME_BITS-2:0], 1'b0};
      end
   end

   // Receive shifter and bit counter; a 33rd rising edge marks the frame as overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_shift <= '0;
         bitcnt   <= '0;
         overrun  <= 1'b0;
      end else if (load_reply) begin
         bitcnt   <= '0;
         overrun  <= 1'b0;
      end else if (shift_in) begin
         rx_shift <= {rx_shift[SPI_FRAME_BITS-2:0], mosi_s};
         if (bitcnt == FRAME_CNT) overrun <= 1'b1;
         else                     bitcnt  <= bitcnt + 1'b1;
      end
   end

   // Completed frames are presented as a one-cycle strobe; index and data hold afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_valid_q <= 1'b0;
         rx_index_q <= '0;
         rx_data_q  <= '0;
      end else begin
         rx_valid_q <= frame_ok;
         if (frame_ok) begin
            rx_index_q <= rx_shift[SPI_FRAME_BITS-1 -: SPI_IDX_BITS];
            rx_data_q  <= rx_shift[SPI_DATA_BITS-1:0];
         end
      end
   end

   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_index = rx_index_q;
   assign bus.rx_data  = rx_data_q;

   assign bus.tx_ready = !fifo_full;
   assign fifo_push    = bus.tx_valid && !fifo_full && (bus.tx_index != SPI_IDX_STATUS);

   spi_tx_fifo #(
      .DEPTH (TXQ_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_word (make_word(bus.tx_index, bus.tx_data)),
      .pop       (fifo_pop),
      .peek_word (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef YABOT_SPI_ERRCNT_EN
   logic [7:0] err_cnt;
   logic       frame_abort;

   assign frame_abort = frame_done && !frame_ok;

   // Saturating count of frames that ended with the wrong number of bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 err_cnt <= 8'h00;
      else if (frame_abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
   end

   assign bus.frame_err = err_cnt;
`else
   assign bus.frame_err = 8'h00;
`endif

endmodule

// File: tb/tb_jetson_spi_slave.sv
// Self-checking bench for jetson_spi_slave: an SPI mode-0 master model drives
// frames while expected received words and MISO replies are queued and popped
// as the design responds. Honours YABOT_SPI_ERRCNT_EN for frame_err.
module tb_jetson_spi_slave;
   import jetson_spi_slave_pkg::*;

   localparam int SYNC_STAGES = 2;
   localparam int TXQ_DEPTH   = 16;
`ifdef YABOT_SPI_ERRCNT_EN
   localparam bit ERRCNT_ON = 1'b1;
`else
   localparam bit ERRCNT_ON = 1'b0;
`endif

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   err_exp;

   logic [31:0] exp_rx_q   [$];
   logic [31:0] exp_miso_q [$];

   jetson_spi_slave_if bus();

   jetson_spi_slave #(
      .SYNC_STAGES (SYNC_STAGES),
      .TXQ_DEPTH   (TXQ_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // SPI master: 60 ns half period, MOSI set before rise, MISO sampled at rise
   task automatic spi_xfer(input logic [31:0] mosi_word, input int nbits,
                           input bit rst_before_cs, output logic [31:0] miso_word);
      miso_word = '0;
      repeat (5) @(negedge clk);
      bus.spi_cs = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         bus.spi_mosi = (i < 32) ? mosi_word[31-i] : 1'b0;
         #60;
         bus.spi_clk = 1'b1;
         if (i < 32) miso_word[31-i] = bus.spi_miso;
         #60;
         bus.spi_clk = 1'b0;
      end
      #60;
      if (rst_before_cs) begin
         rst = 1'b1;
         #20;
      end
      bus.spi_cs   = 1'b1;
      bus.spi_mosi = 1'b0;
   endtask

   // Bounded wait for the received-frame strobe
   task automatic wait_rx(input int budget, output bit got, output logic [31:0] word);
      got  = 1'b0;
      word = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.rx_valid === 1'b1) begin
            got  = 1'b1;
            word = {bus.rx_index, bus.rx_data};
            break;
         end
      end
   endtask

   task automatic push_tx(input logic [3:0] idx, input logic [27:0] data);
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_index = idx;
      bus.tx_data  = data;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic test_reset();
      vectors += 6;
      if (bus.spi_miso !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_miso: got %b expected 0", bus.spi_miso); end
      if (bus.rx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
      if (bus.rx_index !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_rx_index: got %h expected 0", bus.rx_index); end
      if (bus.rx_data !== 28'h0) begin miscompares++; $display("[TB] FAIL reset_rx_data: got %h expected 0", bus.rx_data); end
      if (bus.tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
      if (bus.frame_err !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_frame_err: got %h expected 00", bus.frame_err); end
   endtask

   // Full frame with the expectations already queued; compares rx word and reply
   task automatic test_full_frame(input string name, input logic [31:0] mosi_word);
      logic [31:0] miso;
      logic [31:0] rxw;
      logic [31:0] exp;
      bit          got;
      spi_xfer(mosi_word, 32, 1'b0, miso);
      wait_rx(40, got, rxw);
      vectors += 3;
      if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_rx_valid: got no strobe, expected strobe", name); end
      exp = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 32'hxxxxxxxx;
      if (rxw !== exp) begin miscompares++; $display("[TB] FAIL %s_rx_word: got %h expected %h", name, rxw, exp); end
      exp = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 32'hxxxxxxxx;
      if (miso !== exp) begin miscompares++; $display("[TB] FAIL %s_miso: got %h expected %h", name, miso, exp); end
   endtask

   task automatic test_status_reply();
      bus.status_in = 28'h0ABCDEF;
      exp_rx_q.push_back(32'h3000_0012);
      exp_miso_q.push_back(32'h00AB_CDEF);
      test_full_frame("status_reply", 32'h3000_0012);
      @(negedge clk);
      vectors++;
      if (bus.rx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL strobe_width: got %b expected 0", bus.rx_valid); end
   endtask

   task automatic test_fifo_reply();
      push_tx(4'h5, 28'h1234567);
      exp_rx_q.push_back(32'h1000_0001);
      exp_miso_q.push_back(32'h5123_4567);
      test_full_frame("fifo_reply", 32'h1000_0001);
      exp_rx_q.push_back(32'hA5A5_5A5A);
      exp_miso_q.push_back(32'h00AB_CDEF);
      test_full_frame("after_pop", 32'hA5A5_5A5A);
   endtask

   task automatic test_abort();
      logic [31:0] miso;
      logic [31:0] rxw;
      bit          got;
      push_tx(4'h5, 28'h1234567);
      spi_xfer(32'h7777_7777, 17, 1'b0, miso);
      wait_rx(20, got, rxw);
      if (ERRCNT_ON) err_exp++;
      vectors += 2;
      if (got !== 1'b0) begin miscompares++; $display("[TB] FAIL abort17_rx_valid: got strobe %h, expected none", rxw); end
      if (bus.frame_err !== 8'(err_exp)) begin miscompares++; $display("[TB] FAIL abort17_frame_err: got %h expected %h", bus.frame_err, 8'(err_exp)); end
      spi_xfer(32'h7777_7777, 33, 1'b0, miso);
      wait_rx(20, got, rxw);
      if (ERRCNT_ON) err_exp++;
      vectors += 2;
      if (got !== 1'b0) begin miscompares++; $display("[TB] FAIL abort33_rx_valid: got strobe %h, expected none", rxw); end
      if (bus.frame_err !== 8'(err_exp)) begin miscompares++; $display("[TB] FAIL abort33_frame_err: got %h expected %h", bus.frame_err, 8'(err_exp)); end
      exp_rx_q.push_back(32'h2000_00FF);
      exp_miso_q.push_back(32'h5123_4567);
      test_full_frame("after_abort", 32'h2000_00FF);
   endtask

   task automatic test_fill();
      logic [3:0]  idx;
      logic [27:0] data;
      for (int i = 0; i < TXQ_DEPTH; i++) begin
         vectors++;
         if (bus.tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ready_%0d: got %b expected 1", i, bus.tx_ready); end
         idx  = 4'((i % 15) + 1);
         data = 28'h0100 + 28'(i);
         push_tx(idx, data);
         exp_miso_q.push_back({idx, data});
      end
      vectors++;
      if (bus.tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_full: got %b expected 0", bus.tx_ready); end
      push_tx(4'h9, 28'hFFFFFFF);
      for (int i = 0; i < TXQ_DEPTH; i++) begin
         exp_rx_q.push_back(32'h2000_0000 + 32'(i));
         test_full_frame("fill_drain", 32'h2000_0000 + 32'(i));
         if (i == 0) begin
            vectors++;
            if (bus.tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ready_after_pop: got %b expected 1", bus.tx_ready); end
         end
      end
      exp_rx_q.push_back(32'h2000_00AA);
      exp_miso_q.push_back(32'h00AB_CDEF);
      test_full_frame("fill_empty", 32'h2000_00AA);
   endtask

   task automatic test_zero_index();
      logic [31:0] miso;
      logic [31:0] rxw;
      bit          got;
      push_tx(4'h0, 28'h7777777);
      vectors++;
      if (bus.tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_idx_ready: got %b expected 1", bus.tx_ready); end
      exp_rx_q.push_back(32'h6000_0C0D);
      exp_miso_q.push_back(32'h00AB_CDEF);
      fork
         spi_xfer(32'h6000_0C0D, 32, 1'b0, miso);
         begin
            #1500;
            bus.status_in = 28'h5555555;
         end
      join
      wait_rx(40, got, rxw);
      vectors += 3;
      if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_idx_rx_valid: got no strobe, expected strobe"); end
      if (rxw !== exp_rx_q[0]) begin miscompares++; $display("[TB] FAIL zero_idx_rx_word: got %h expected %h", rxw, exp_rx_q[0]); end
      if (miso !== exp_miso_q[0]) begin miscompares++; $display("[TB] FAIL zero_idx_miso: got %h expected %h", miso, exp_miso_q[0]); end
      void'(exp_rx_q.pop_front());
      void'(exp_miso_q.pop_front());
      exp_rx_q.push_back(32'h6000_0C0E);
      exp_miso_q.push_back(32'h0555_5555);
      test_full_frame("new_status", 32'h6000_0C0E);
      bus.status_in = 28'h0ABCDEF;
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] miso;
      push_tx(4'h7, 28'h0C0FFEE);
      spi_xfer(32'h4000_0000, 10, 1'b1, miso);
      @(negedge clk);
      err_exp = 0;
      vectors += 6;
      if (bus.spi_miso !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_miso: got %b expected 0", bus.spi_miso); end
      if (bus.rx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_rx_valid: got %b expected 0", bus.rx_valid); end
      if (bus.rx_index !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_rx_index: got %h expected 0", bus.rx_index); end
      if (bus.rx_data !== 28'h0) begin miscompares++; $display("[TB] FAIL midrst_rx_data: got %h expected 0", bus.rx_data); end
      if (bus.tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_tx_ready: got %b expected 1", bus.tx_ready); end
      if (bus.frame_err !== 8'(err_exp)) begin miscompares++; $display("[TB] FAIL midrst_frame_err: got %h expected %h", bus.frame_err, 8'(err_exp)); end
      rst = 1'b0;
      exp_rx_q.push_back(32'hF123_4567);
      exp_miso_q.push_back(32'h00AB_CDEF);
      test_full_frame("after_midrst", 32'hF123_4567);
      vectors++;
      if (bus.frame_err !== 8'(err_exp)) begin miscompares++; $display("[TB] FAIL after_midrst_frame_err: got %h expected %h", bus.frame_err, 8'(err_exp)); end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      err_exp       = 0;
      rst           = 1'b1;
      bus.spi_clk   = 1'b0;
      bus.spi_cs    = 1'b1;
      bus.spi_mosi  = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.tx_index  = 4'h0;
      bus.tx_data   = 28'h0;
      bus.status_in = 28'h0ABCDEF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] starting jetson_spi_slave bench");
      test_reset();
      test_status_reply();
      test_fifo_reply();
      test_abort();
      test_fill();
      test_zero_index();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
